// File: rtl/img_stream_tx_if.sv
// Frame-buffer read port plus pixel output stream of img_stream_tx.
// master = the streamer, slave = frame buffer / feature pipeline side.
interface img_stream_tx_if #(
  parameter int ADDR_W = 19
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic [7:0]        img_dout;
  logic              img_dout_valid;
  logic [9:0]        col_cnt;
  logic [9:0]        row_cnt;
  logic              sof;
  logic              eol;
  logic              eof;

  modport master (
    output mem_rd_en, mem_addr,
    input  mem_rdata,
    output img_dout, img_dout_valid, col_cnt, row_cnt, sof, eol, eof
  );

  modport slave (
    input  mem_rd_en, mem_addr,
    output mem_rdata,
    input  img_dout, img_dout_valid, col_cnt, row_cnt, sof, eol, eof
  );
endinterface

// File: rtl/img_stream_tx.sv
// Streams one frame from a frame buffer in raster order after a fixed idle gap,
// tagging each pixel with its coordinates and sof/eol/eof markers.
//
//   state  | meaning
//   IDLE   | waiting for start (ignored in the frame_done cycle)
//   GAP    | idle gap, down-counter runs to terminal count 0
//   STREAM | one buffer read per cycle while pause is low
//   DRAIN  | last pixel (eof) on the output, no reads
module img_stream_tx #(
  parameter int IMG_WIDTH  = 120,
  parameter int IMG_HEIGHT = 100,
  parameter int GAP_CYCLES = 1000,
  parameter int ADDR_W     = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] frame_base,
  input  logic              pause,
  output logic              busy,
  output logic              frame_done,
  img_stream_tx_if.master   bus
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
  localparam logic [9:0]       COL_LAST = 10'(IMG_WIDTH - 1);
  localparam logic [9:0]       ROW_LAST = 10'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GAP    = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [9:0]        rd_col_q, rd_col_d;
  logic [9:0]        rd_row_q, rd_row_d;
  logic [9:0]        col_q, col_d;
  logic [9:0]        row_q, row_d;
  logic              valid_q, valid_d;
  logic              sof_q, sof_d;
  logic              eol_q, eol_d;
  logic              eof_q, eof_d;
  logic              done_q, done_d;

  logic              start_ok;
  logic              rd_en;
  logic              rd_last;
  logic              gap_tc;

  // The frame_done cycle is an IDLE cycle, but a start there must be dropped.
  assign start_ok = (state_q == IDLE) && start && !done_q;
  assign rd_last  = (rd_col_q == COL_LAST) && (rd_row_q == ROW_LAST);
  assign gap_tc   = (gap_cnt_q == '0);

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok)         state_d = GAP;
      GAP:     if (gap_tc)           state_d = STREAM;
      STREAM:  if (rd_en && rd_last) state_d = DRAIN;
      DRAIN:                         state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  // state outputs
  always_comb begin
    busy  = (state_q != IDLE);
    rd_en = (state_q == STREAM) && !pause;
  end

  // datapath next values
  always_comb begin
    gap_cnt_d = gap_cnt_q;
    addr_d    = addr_q;
    rd_col_d  = rd_col_q;
    rd_row_d  = rd_row_q;
    col_d     = col_q;
    row_d     = row_q;
    valid_d   = rd_en;
    sof_d     = rd_en && (rd_col_q == '0) && (rd_row_q == '0);
    eol_d     = rd_en && (rd_col_q == COL_LAST);
    eof_d     = rd_en && rd_last;
    done_d    = (state_q == DRAIN);

    if (start_ok) begin
      gap_cnt_d = GAP_LOAD;
      addr_d    = frame_base;
      rd_col_d  = '0;
      rd_row_d  = '0;
      col_d     = '0;
      row_d     = '0;
    end else if ((state_q == GAP) && !gap_tc) begin
      gap_cnt_d = gap_cnt_q - 1'b1;
    end

    // Output coordinates follow the read that produced the pixel, so a paused
    // cycle leaves them untouched for the matching valid gap.
    if (rd_en) begin
      addr_d = addr_q + ADDR_W'(1);
      col_d  = rd_col_q;
      row_d  = rd_row_q;
      if (rd_col_q == COL_LAST) begin
        rd_col_d = '0;
        rd_row_d = rd_row_q + 10'd1;
      end else begin
        rd_col_d = rd_col_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gap_cnt_q <= '0;
      addr_q    <= '0;
      rd_col_q  <= '0;
      rd_row_q  <= '0;
      col_q     <= '0;
      row_q     <= '0;
      valid_q   <= 1'b0;
      sof_q     <= 1'b0;
      eol_q     <= 1'b0;
      eof_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      gap_cnt_q <= gap_cnt_d;
      addr_q    <= addr_d;
      rd_col_q  <= rd_col_d;
      rd_row_q  <= rd_row_d;
      col_q     <= col_d;
      row_q     <= row_d;
      valid_q   <= valid_d;
      sof_q     <= sof_d;
      eol_q     <= eol_d;
      eof_q     <= eof_d;
      done_q    <= done_d;
    end
  end

  // Buffer data arrives one cycle after the read, i.e. alongside valid_q.
  assign bus.mem_rd_en      = rd_en;
  assign bus.mem_addr       = addr_q;
  assign bus.img_dout       = valid_q ? bus.mem_rdata : 8'd0;
  assign bus.img_dout_valid = valid_q;
  assign bus.col_cnt        = col_q;
  assign bus.row_cnt        = row_q;
  assign bus.sof            = sof_q;
  assign bus.eol            = eol_q;
  assign bus.eof            = eof_q;
  assign frame_done         = done_q;

endmodule

// File: tb/tb_img_stream_tx.sv
// Bench for img_stream_tx: directed frames checked cycle by cycle against a
// raster-order model of addresses, pixels and coordinates.
module tb_img_stream_tx;
  localparam int W    = 4;
  localparam int H    = 3;
  localparam int G    = 5;
  localparam int AW   = 19;
  localparam int NPIX = W * H;

  typedef struct packed {
    logic [7:0] data;
    logic [9:0] col;
    logic [9:0] row;
    logic       sof;
    logic       eol;
    logic       eof;
  } pix_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic [AW-1:0] frame_base = '0;
  logic          busy;
  logic          frame_done;

  img_stream_tx_if #(.ADDR_W(AW)) bus ();

  img_stream_tx #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .GAP_CYCLES(G),
    .ADDR_W    (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .frame_base(frame_base),
    .pause     (pause),
    .busy      (busy),
    .frame_done(frame_done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // frame buffer: word n holds n mod 256, returned one cycle after the read
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rdata <= bus.mem_addr[7:0];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pix_t pq[$];
  int   aq[$];
  pix_t exp_pix;

  int checks = 0;
  int errors = 0;
  int start_cyc = -1, first_rd_cyc = -1, done_cyc = -1;
  int n_pix = 0, n_vgap = 0, n_reads = 0, busy_low = 0, n_eol = 0;
  logic [7:0] first_data, last_data;
  bit saw_zero = 0;
  bit prev_rst = 1, prev_rd = 0, prev_last = 0;
  logic [9:0] prev_col = '0, prev_row = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void expect_frame(input int base);
    pix_t p;
    for (int k = 0; k < NPIX; k++) begin
      int a;
      a = (base + k) % (1 << AW);
      aq.push_back(a);
      p.data = 8'(a % 256);
      p.col  = 10'(k % W);
      p.row  = 10'(k / W);
      p.sof  = (k == 0);
      p.eol  = ((k % W) == W - 1);
      p.eof  = (k == NPIX - 1);
      pq.push_back(p);
    end
  endfunction

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (prev_rst) begin
        chk("reset_zero", {busy, frame_done, bus.mem_rd_en, bus.img_dout_valid,
                           bus.sof, bus.eol, bus.eof, |bus.mem_addr, |bus.img_dout,
                           |bus.col_cnt, |bus.row_cnt}, 32'd0);
        prev_last = 0;
      end else begin
        chk("valid_latency", bus.img_dout_valid, prev_rd);
        chk("frame_done", frame_done, prev_last);
        if (frame_done) done_cyc = cyc;
        if (bus.mem_rd_en) begin
          chk("rd_while_pause", pause, 0);
          n_reads++;
          if (first_rd_cyc < 0) first_rd_cyc = cyc;
          if (bus.mem_addr == '0) saw_zero = 1;
          if (aq.size() == 0) chk("extra_read", 1, 0);
          else chk("mem_addr", 32'(bus.mem_addr), aq.pop_front());
        end
        prev_last = 0;
        if (bus.img_dout_valid) begin
          if (pq.size() == 0) chk("extra_pixel", 1, 0);
          else begin
            exp_pix = pq.pop_front();
            chk("pixel", {bus.img_dout, bus.col_cnt, bus.row_cnt, bus.sof, bus.eol, bus.eof},
                exp_pix);
            prev_last = exp_pix.eof;
          end
          if (n_pix == 0) first_data = bus.img_dout;
          last_data = bus.img_dout;
          if (bus.eol) n_eol++;
          n_pix++;
        end else if (n_pix > 0 && pq.size() > 0) begin
          n_vgap++;
          chk("coord_hold", {bus.col_cnt, bus.row_cnt}, {prev_col, prev_row});
        end
        if (start_cyc >= 0 && cyc > start_cyc && done_cyc < 0 && !busy) busy_low++;
      end
    end
    prev_rst = rst;
    prev_rd  = bus.mem_rd_en;
    prev_col = bus.col_cnt;
    prev_row = bus.row_cnt;
  end

  task automatic launch(input int base, input bit clr);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    start      = 1'b1;
    frame_base = AW'(base);
    if (clr) begin
      pq.delete();
      aq.delete();
    end
    expect_frame(base);
    start_cyc    = cyc;
    first_rd_cyc = -1;
    done_cyc     = -1;
    n_pix = 0; n_vgap = 0; n_reads = 0; busy_low = 0; n_eol = 0;
    saw_zero = 0;
  endtask

  task automatic drop_start();
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("start_coords", {bus.col_cnt, bus.row_cnt}, 0);
    chk("start_busy", busy, 1);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cyc < 0; i++) @(negedge clk);
    chk("done_timeout", done_cyc >= 0, 1);
  endtask

  task automatic frame_summary(input int fdata, input int ldata, input int vgap, input int done_rel);
    chk("pix_count", n_pix, NPIX);
    chk("read_count", n_reads, NPIX);
    chk("gap_len", first_rd_cyc - start_cyc, G + 1);
    chk("first_data", first_data, fdata);
    chk("last_data", last_data, ldata);
    chk("eol_count", n_eol, H);
    chk("valid_gap", n_vgap, vgap);
    chk("busy_cont", busy_low, 0);
    chk("done_time", done_cyc - start_cyc, done_rel);
    chk("queues_empty", pq.size() + aq.size(), 0);
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", bus.img_dout_valid, 0);

    // plain frame, started in the first cycle after reset release
    launch(0, 0);
    drop_start();
    wait_done(100);
    frame_summary(0, 11, 0, 19);

    // pause during GAP (no effect) and for two cycles at the 6th read
    launch(100, 0);
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      pause = (k == 2) || (k == 11) || (k == 12);
    end
    pause = 1'b0;
    wait_done(50);
    frame_summary(100, 111, 2, 21);

    // starts while busy and in the frame_done cycle are ignored
    launch(20, 0);
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk);
      #1;
      start      = (k == 2) || (k == 10) || (k == 19);
      frame_base = AW'(200);
    end
    start = 1'b0;
    wait_done(50);
    frame_summary(20, 31, 0, 19);
    repeat (10) @(negedge clk);
    chk("no_restart_reads", n_reads, NPIX);
    chk("no_restart_busy", busy, 0);

    // reset on the 7th valid pixel, then a fresh frame
    launch(0, 0);
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      rst   = (k == 13);
    end
    launch(0, 1);
    @(negedge clk);
    chk("midrst_valid", bus.img_dout_valid, 0);
    chk("midrst_busy", busy, 0);
    drop_start();
    wait_done(100);
    frame_summary(0, 11, 0, 19);

    // address wrap at the top of the buffer
    launch((1 << AW) - 4, 0);
    drop_start();
    wait_done(100);
    frame_summary(252, 7, 0, 19);
    chk("addr_wrap_seen", saw_zero, 1);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
